// File: rtl/mdio_pkg.sv
// mdio_pkg: shared FSM state, frame encodings and T_DATA field layout for the MDIO master
package mdio_pkg;
   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA} mdio_state_t;
   localparam logic [1:0] ST_CL22      = 2'b01;
   localparam logic [1:0] ST_CL45      = 2'b00;
   localparam logic [1:0] OP_C45_ADDR  = 2'b00;
   localparam logic [1:0] OP_WRITE     = 2'b01;
   localparam logic [1:0] OP_C22_READ  = 2'b10;
   localparam logic [1:0] OP_C45_RDINC = 2'b10;
   localparam logic [1:0] OP_C45_READ  = 2'b11;
   localparam int ST_LSB    = 30;
   localparam int OP_LSB    = 28;
   localparam int ADDR1_LSB = 23;
   localparam int ADDR2_LSB = 18;
   localparam int TA_LSB    = 16;
   localparam int DATA_LSB  = 0;
   localparam int HDR_BITS  = 14;
   localparam int TA_BITS   = 2;
   // OP[1] set marks every read flavour (Cl22 read, Cl45 read and post-read-increment)
   function automatic logic is_read(input logic [31:0] frame);
      return frame[OP_LSB+1];
   endfunction
endpackage

// File: rtl/mdio_clk_gen.sv
// mdio_clk_gen: MDC divider with one-clk strobes on the cycle before each MDC edge
module mdio_clk_gen #(
   parameter int MDC_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic mdc,
   output logic mdc_rise,
   output logic mdc_fall
);
   localparam int CW = $clog2(MDC_DIV);
   logic [CW-1:0] cnt;
   logic          wrap;
   assign wrap     = cnt == CW'(MDC_DIV - 1);
   assign mdc_rise = en && !mdc && wrap;
   assign mdc_fall = en && mdc && wrap;
   // half-period counter; held cleared with MDC low whenever no frame is running
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt <= '0;
         mdc <= 1'b0;
      end else begin
         cnt <= wrap ? '0 : cnt + 1'b1;
         if (wrap) mdc <= ~mdc;
      end
   end
endmodule

// File: rtl/mdio_master_param.sv
// mdio_master_param: MDIO master serialising a 32-bit Cl22/Cl45 frame; MDIO_PRESUP_EN adds per-frame preamble suppression
module mdio_master_param
   import mdio_pkg::*;
#(
   parameter int MDC_DIV = 4,
   parameter int PRE_LEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MDIO_START,
   input  logic [31:0] T_DATA,
`ifdef MDIO_PRESUP_EN
   input  logic        PRE_SUP,
`endif
   input  logic        MDIO_IN,
   output logic        MDC,
   output logic        MDIO_OUT,
   output logic        MDIO_OE,
   output logic [15:0] RD_DATA,
   output logic        DATA_RDY,
   output logic        BUSY
);
   localparam int PW = (PRE_LEN > 0) ? $clog2(PRE_LEN + 1) : 1;
   mdio_state_t   state;
   logic [31:0]   sreg;
   logic [15:0]   sin;
   logic [PW-1:0] pcnt;
   logic [4:0]    bcnt;
   logic          rd;
   logic          skip_pre;
   logic          mdc_rise;
   logic          mdc_fall;
`ifdef MDIO_PRESUP_EN
   assign skip_pre = (PRE_LEN == 0) || PRE_SUP;
`else
   assign skip_pre = (PRE_LEN == 0);
`endif
   mdio_clk_gen #(.MDC_DIV(MDC_DIV)) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .en       (BUSY),
      .mdc      (MDC),
      .mdc_rise (mdc_rise),
      .mdc_fall (mdc_fall)
   );
   // frame FSM: each MDC falling strobe ends one bit and launches the next on MDIO_OUT
   always_ff @(posedge clk) begin
      DATA_RDY <= 1'b0;
      if (rst) begin
         state    <= IDLE;
         BUSY     <= 1'b0;
         MDIO_OUT <= 1'b0;
         MDIO_OE  <= 1'b0;
         RD_DATA  <= '0;
         sreg     <= '0;
         sin      <= '0;
         pcnt     <= '0;
         bcnt     <= '0;
         rd       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (MDIO_START) begin
               BUSY    <= 1'b1;
               MDIO_OE <= 1'b1;
               rd      <= is_read(T_DATA);
               pcnt    <= '0;
               bcnt    <= '0;
               if (skip_pre) begin
                  state    <= HDR;
                  MDIO_OUT <= T_DATA[31];
                  sreg     <= {T_DATA[30:0], 1'b0};
               end else begin
                  state    <= PRE;
                  MDIO_OUT <= 1'b1;
                  sreg     <= T_DATA;
               end
            end
            PRE: if (mdc_fall) begin
               if (pcnt == PW'(PRE_LEN - 1)) begin
                  state    <= HDR;
                  MDIO_OUT <= sreg[31];
                  sreg     <= {sreg[30:0], 1'b0};
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            end
            default: begin
               if (mdc_rise && state == DATA) sin <= {sin[14:0], MDIO_IN};
               if (mdc_fall) begin
                  if (bcnt == 5'd31) begin
                     state    <= IDLE;
                     BUSY     <= 1'b0;
                     MDIO_OE  <= 1'b0;
                     MDIO_OUT <= 1'b0;
                     if (rd) begin
                        RD_DATA  <= sin;
                        DATA_RDY <= 1'b1;
                     end
                  end else begin
                     bcnt  <= bcnt + 1'b1;
                     state <= (bcnt == 5'(HDR_BITS - 1)) ? TA :
                              (bcnt == 5'(HDR_BITS + TA_BITS - 1)) ? DATA : state;
                     if (rd && bcnt >= 5'(HDR_BITS - 1)) begin
                        MDIO_OE  <= 1'b0;
                        MDIO_OUT <= 1'b0;
                     end else begin
                        MDIO_OUT <= sreg[31];
                        sreg     <= {sreg[30:0], 1'b0};
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mdio_master_param.sv
// tb_mdio_master_param: directed frame tests for two MDIO master configurations
module tb_mdio_master_param;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start1 = 1'b0;
   logic        start2 = 1'b0;
   logic [31:0] t_data = '0;
   logic        mdio_in = 1'b0;
   logic        mdc1, out1, oe1, rdy1, busy1;
   logic        mdc2, out2, oe2, rdy2, busy2;
   logic [15:0] rd1, rd2;
   int          checks = 0;
   int          failures = 0;
   int          busy_cyc, nbits, glitch, mid_rdy, mdc_hi;
   logic [95:0] cap_out, cap_oe;
   logic        first_busy, first_oe, first_out, end_rdy, end_mdc, end_oe;
   logic [15:0] end_rd;

   always #5 clk = ~clk;

   mdio_master_param #(.MDC_DIV(4), .PRE_LEN(32)) dut1 (
      .clk(clk), .rst(rst), .MDIO_START(start1), .T_DATA(t_data),
`ifdef MDIO_PRESUP_EN
      .PRE_SUP(1'b0),
`endif
      .MDIO_IN(mdio_in), .MDC(mdc1), .MDIO_OUT(out1), .MDIO_OE(oe1),
      .RD_DATA(rd1), .DATA_RDY(rdy1), .BUSY(busy1)
   );

   mdio_master_param #(.MDC_DIV(2), .PRE_LEN(0)) dut2 (
      .clk(clk), .rst(rst), .MDIO_START(start2), .T_DATA(t_data),
`ifdef MDIO_PRESUP_EN
      .PRE_SUP(1'b1),
`endif
      .MDIO_IN(mdio_in), .MDC(mdc2), .MDIO_OUT(out2), .MDIO_OE(oe2),
      .RD_DATA(rd2), .DATA_RDY(rdy2), .BUSY(busy2)
   );

   // Called at a negedge: requests a frame, records one MDIO_OUT/OE sample per bit and plays the PHY.
   task automatic run_frame(input int sel, input logic [31:0] td, input int pre,
                            input logic [15:0] phy, input int poke_at, input logic [31:0] poke_td);
      logic b, m, o, e, y, pm, last_o;
      logic [15:0] rdv, phy_sh;
      int f;
      busy_cyc = 0; nbits = 0; glitch = 0; mid_rdy = 0; mdc_hi = 0;
      cap_out = '0; cap_oe = '0; pm = 1'b1; last_o = 1'b0; phy_sh = phy;
      t_data = td;
      if (sel == 1) start2 = 1'b1; else start1 = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         start1 = 1'b0;
         start2 = 1'b0;
         if (c == poke_at) begin
            t_data = poke_td;
            if (sel == 1) start2 = 1'b1; else start1 = 1'b1;
         end
         b   = (sel == 1) ? busy2 : busy1;
         m   = (sel == 1) ? mdc2  : mdc1;
         o   = (sel == 1) ? out2  : out1;
         e   = (sel == 1) ? oe2   : oe1;
         y   = (sel == 1) ? rdy2  : rdy1;
         rdv = (sel == 1) ? rd2   : rd1;
         if (c == 0) begin
            first_busy = b; first_oe = e; first_out = o;
         end
         if (!b) begin
            end_rdy = y; end_mdc = m; end_oe = e; end_rd = rdv;
            return;
         end
         busy_cyc++;
         if (m) mdc_hi++;
         if (y) mid_rdy++;
         if (!m && pm) begin
            cap_out = {cap_out[94:0], o};
            cap_oe  = {cap_oe[94:0], e};
            f = nbits - pre;
            if (f >= 16) begin
               mdio_in = phy_sh[15];
               phy_sh  = {phy_sh[14:0], 1'b0};
            end else begin
               mdio_in = 1'b0;
            end
            nbits++;
            last_o = o;
         end else if (o !== last_o) begin
            glitch++;
         end
         pm = m;
      end
      checks++; failures++;
      $display("FAIL frame_timeout: busy_cyc=%0d still busy, required end within 4000", busy_cyc);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({mdc1, out1, oe1, rdy1, busy1, rd1} !== 21'd0) begin
         failures++;
         $display("FAIL reset_dut1: got %h required 0", {mdc1, out1, oe1, rdy1, busy1, rd1});
      end
      checks++;
      if ({mdc2, out2, oe2, rdy2, busy2, rd2} !== 21'd0) begin
         failures++;
         $display("FAIL reset_dut2: got %h required 0", {mdc2, out2, oe2, rdy2, busy2, rd2});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cl22_write();
      run_frame(0, 32'h5082ABCD, 32, 16'h0, -1, 32'h0);
      checks++;
      if ({first_busy, first_oe, first_out} !== 3'b111) begin
         failures++;
         $display("FAIL wr_latency: busy/oe/out=%b required 111", {first_busy, first_oe, first_out});
      end
      checks++;
      if (busy_cyc !== 512 || nbits !== 64) begin
         failures++;
         $display("FAIL wr_length: busy=%0d bits=%0d required 512/64", busy_cyc, nbits);
      end
      checks++;
      if (cap_out[63:0] !== {32'hFFFFFFFF, 32'h5082ABCD}) begin
         failures++;
         $display("FAIL wr_stream: got %h required ffffffff5082abcd", cap_out[63:0]);
      end
      checks++;
      if (cap_oe[63:0] !== {64{1'b1}}) begin
         failures++;
         $display("FAIL wr_oe: got %h required all ones", cap_oe[63:0]);
      end
      checks++;
      if (glitch !== 0 || mdc_hi !== 256) begin
         failures++;
         $display("FAIL wr_timing: glitches=%0d mdc_high=%0d required 0/256", glitch, mdc_hi);
      end
      checks++;
      if ({mid_rdy != 0, end_rdy, end_mdc, end_oe} !== 4'b0000) begin
         failures++;
         $display("FAIL wr_end: rdy_mid/rdy/mdc/oe=%b required 0000", {mid_rdy != 0, end_rdy, end_mdc, end_oe});
      end
   endtask

   task automatic test_cl22_read();
      run_frame(0, 32'h60880000, 32, 16'h1234, -1, 32'h0);
      checks++;
      if (cap_out[63:0] !== {32'hFFFFFFFF, 32'h60880000 & 32'hFFFC0000}) begin
         failures++;
         $display("FAIL rd_stream: got %h required ffffffff60880000", cap_out[63:0]);
      end
      checks++;
      if (cap_oe[63:0] !== {{46{1'b1}}, 18'd0}) begin
         failures++;
         $display("FAIL rd_oe: got %h required %h", cap_oe[63:0], {{46{1'b1}}, 18'd0});
      end
      checks++;
      if (end_rd !== 16'h1234 || end_rdy !== 1'b1 || mid_rdy !== 0 || end_oe !== 1'b0) begin
         failures++;
         $display("FAIL rd_data: rd=%h rdy=%b mid=%0d oe=%b required 1234/1/0/0", end_rd, end_rdy, mid_rdy, end_oe);
      end
      checks++;
      if (busy_cyc !== 512) begin
         failures++;
         $display("FAIL rd_length: got %0d required 512", busy_cyc);
      end
      @(negedge clk);
      checks++;
      if (rdy1 !== 1'b0 || rd1 !== 16'h1234) begin
         failures++;
         $display("FAIL rd_hold: rdy=%b rd=%h required 0/1234", rdy1, rd1);
      end
   endtask

   task automatic test_back_to_back();
      run_frame(0, 32'h01860010, 32, 16'h0, -1, 32'h0);
      checks++;
      if (cap_out[63:0] !== {32'hFFFFFFFF, 32'h01860010} || end_rdy !== 1'b0) begin
         failures++;
         $display("FAIL b2b_addr: got %h rdy=%b required ffffffff01860010/0", cap_out[63:0], end_rdy);
      end
      // Cl45 read: ST=00 OP=11 PRTAD=3 DEVAD=1, issued on the first idle cycle
      run_frame(0, 32'h31860000, 32, 16'hBEEF, -1, 32'h0);
      checks++;
      if (first_busy !== 1'b1 || busy_cyc !== 512) begin
         failures++;
         $display("FAIL b2b_accept: busy=%b len=%0d required 1/512", first_busy, busy_cyc);
      end
      checks++;
      if (end_rd !== 16'hBEEF || end_rdy !== 1'b1) begin
         failures++;
         $display("FAIL b2b_read: rd=%h rdy=%b required beef/1", end_rd, end_rdy);
      end
   endtask

   task automatic test_start_ignored();
      run_frame(0, 32'h5082ABCD, 32, 16'h0, 100, 32'h6FFF0000);
      checks++;
      if (cap_out[63:0] !== {32'hFFFFFFFF, 32'h5082ABCD} || busy_cyc !== 512) begin
         failures++;
         $display("FAIL start_ignored: got %h len=%0d required ffffffff5082abcd/512", cap_out[63:0], busy_cyc);
      end
      checks++;
      if (cap_oe[63:0] !== {64{1'b1}} || end_rdy !== 1'b0) begin
         failures++;
         $display("FAIL start_ignored_oe: oe=%h rdy=%b required all ones/0", cap_oe[63:0], end_rdy);
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      t_data = 32'h60880000;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat ((32 + 20) * 8) @(negedge clk);
      checks++;
      if (busy1 !== 1'b1 || oe1 !== 1'b0) begin
         failures++;
         $display("FAIL mid_state: busy=%b oe=%b required 1/0", busy1, oe1);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({mdc1, out1, oe1, rdy1, busy1, rd1} !== 21'd0) begin
         failures++;
         $display("FAIL mid_reset: got %h required 0", {mdc1, out1, oe1, rdy1, busy1, rd1});
      end
      rst = 1'b0;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (rdy1 || busy1) seen++;
      end
      checks++;
      if (seen !== 0) begin
         failures++;
         $display("FAIL mid_quiet: %0d active cycles required 0", seen);
      end
      run_frame(0, 32'h60880000, 32, 16'hA5C3, -1, 32'h0);
      checks++;
      if (end_rd !== 16'hA5C3 || end_rdy !== 1'b1 || busy_cyc !== 512) begin
         failures++;
         $display("FAIL mid_recover: rd=%h rdy=%b len=%0d required a5c3/1/512", end_rd, end_rdy, busy_cyc);
      end
   endtask

   task automatic test_short_frame();
      run_frame(1, 32'h5082ABCD, 0, 16'h0, -1, 32'h0);
      checks++;
      if (busy_cyc !== 128 || nbits !== 32 || mdc_hi !== 64) begin
         failures++;
         $display("FAIL short_len: busy=%0d bits=%0d high=%0d required 128/32/64", busy_cyc, nbits, mdc_hi);
      end
      checks++;
      if (cap_out[31:0] !== 32'h5082ABCD || first_out !== 1'b0) begin
         failures++;
         $display("FAIL short_stream: got %h first=%b required 5082abcd/0", cap_out[31:0], first_out);
      end
      run_frame(1, 32'h60880000, 0, 16'h0F0F, -1, 32'h0);
      checks++;
      if (end_rd !== 16'h0F0F || end_rdy !== 1'b1 || cap_oe[31:0] !== {{14{1'b1}}, 18'd0}) begin
         failures++;
         $display("FAIL short_read: rd=%h rdy=%b oe=%h required 0f0f/1/fffc0000", end_rd, end_rdy, cap_oe[31:0]);
      end
   endtask

   initial begin
      test_reset();
      test_cl22_write();
      test_cl22_read();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid();
      test_short_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
